// File: rtl/count_step_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : count_step_monitor
//  Description : Deglitches a 4-bit ripple up/down count with a stability
//                window, tracks accepted values and classifies each change
//                as +1 / -1 / illegal jump. Emits step, wrap, match and
//                direction-error pulses, a sticky jump error and saturating
//                up/down step tallies.
//  Revision    : 1.0  initial release
// ============================================================================
module count_step_monitor #(
    parameter int STABLE_CYCLES = 2,
    parameter int TALLY_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         count_in,
    input  logic               dir_up,
    input  logic [3:0]         cmp_val,
    input  logic               clr_err,
    output logic [3:0]         count_q,
    output logic               valid,
    output logic               step_up,
    output logic               step_down,
    output logic               wrap,
    output logic               match,
    output logic               dir_err,
    output logic               jump_err,
    output logic [TALLY_W-1:0] up_tally,
    output logic [TALLY_W-1:0] down_tally
);

    // Stability counter only needs to reach STABLE_CYCLES, then it saturates.
    localparam int                  c_STAB_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_MAX  = c_STAB_W'(STABLE_CYCLES);
    localparam logic [TALLY_W-1:0]  c_TALLY_MAX = {TALLY_W{1'b1}};

    // IDLE: nothing accepted since reset; TRACK: count_q holds a real value.
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_TRACK = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [3:0]          r_cand;
    logic [c_STAB_W-1:0] r_stab_cnt;

    logic                w_stable;
    logic                w_accept;
    logic [3:0]          w_diff;
    logic                w_is_up;
    logic                w_is_down;
    logic                w_is_jump;
    logic                w_wrap;
    logic                w_dir_err;

    // Candidate filter: restart the window on any change, otherwise count up to the window length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand     <= 4'd0;
            r_stab_cnt <= '0;
        end else if (count_in != r_cand) begin
            r_cand     <= count_in;
            r_stab_cnt <= c_STAB_W'(1);
        end else if (r_stab_cnt != c_STAB_MAX) begin
            r_stab_cnt <= r_stab_cnt + c_STAB_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: the first accepted value moves us to TRACK for good.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_IDLE && w_accept) begin
            w_state_nxt = c_TRACK;
        end
    end

    // FSM outputs: acceptance decision and classification of the accepted change.
    always_comb begin
        w_stable  = (r_stab_cnt == c_STAB_MAX);
        w_accept  = w_stable && ((r_state == c_IDLE) || (r_cand != count_q));
        w_diff    = r_cand - count_q;
        w_is_up   = 1'b0;
        w_is_down = 1'b0;
        w_is_jump = 1'b0;
        w_wrap    = 1'b0;
        w_dir_err = 1'b0;
        if (w_accept && r_state == c_TRACK) begin
            if (w_diff == 4'd1) begin
                w_is_up   = 1'b1;
                w_wrap    = (count_q == 4'd15);
                w_dir_err = !dir_up;
            end else if (w_diff == 4'd15) begin
                w_is_down = 1'b1;
                w_wrap    = (count_q == 4'd0);
                w_dir_err = dir_up;
            end else begin
                w_is_jump = 1'b1;
            end
        end
    end

    // Accepted value, valid flag and single-cycle event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 4'd0;
            valid     <= 1'b0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            wrap      <= 1'b0;
            match     <= 1'b0;
            dir_err   <= 1'b0;
        end else begin
            step_up   <= w_is_up;
            step_down <= w_is_down;
            wrap      <= w_wrap;
            dir_err   <= w_dir_err;
            match     <= w_accept && (r_cand == cmp_val);
            if (w_accept) begin
                count_q <= r_cand;
                valid   <= 1'b1;
            end
        end
    end

    // Sticky jump error; a new jump wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_err <= 1'b0;
        end else if (w_is_jump) begin
            jump_err <= 1'b1;
        end else if (clr_err) begin
            jump_err <= 1'b0;
        end
    end

    // Saturating step tallies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_tally   <= '0;
            down_tally <= '0;
        end else begin
            if (w_is_up && up_tally != c_TALLY_MAX) begin
                up_tally <= up_tally + TALLY_W'(1);
            end
            if (w_is_down && down_tally != c_TALLY_MAX) begin
                down_tally <= down_tally + TALLY_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_step_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_step_monitor
//  Description : Self-checking bench for count_step_monitor. A history-based
//                reference model predicts every output each cycle; directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_step_monitor;

    localparam int S  = 2;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    count_in;
    logic          dir_up;
    logic [3:0]    cmp_val;
    logic          clr_err;
    logic [3:0]    count_q;
    logic          valid;
    logic          step_up;
    logic          step_down;
    logic          wrap;
    logic          match;
    logic          dir_err;
    logic          jump_err;
    logic [TW-1:0] up_tally;
    logic [TW-1:0] down_tally;

    always #5 clk = ~clk;

    count_step_monitor #(.STABLE_CYCLES(S), .TALLY_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .dir_up     (dir_up),
        .cmp_val    (cmp_val),
        .clr_err    (clr_err),
        .count_q    (count_q),
        .valid      (valid),
        .step_up    (step_up),
        .step_down  (step_down),
        .wrap       (wrap),
        .match      (match),
        .dir_err    (dir_err),
        .jump_err   (jump_err),
        .up_tally   (up_tally),
        .down_tally (down_tally)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: raw sample history since reset plus last accepted value.
    logic [3:0] hist[$];
    int m_count_q = 0;
    bit m_valid = 0, m_up = 0, m_dn = 0, m_wrap = 0, m_match = 0, m_derr = 0, m_jerr = 0;
    int m_ut = 0, m_dt = 0;

    // Observed DUT pulse counts (compared against hand-computed literals).
    int n_up = 0, n_dn = 0, n_wrap = 0, n_match = 0, n_derr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the outputs after this edge from the sample history and previous accepted value.
    task automatic model_step();
        bit stable;
        bit jset;
        int d;
        int cand;
        m_up = 0; m_dn = 0; m_wrap = 0; m_match = 0; m_derr = 0;
        if (reset) begin
            hist.delete();
            m_count_q = 0; m_valid = 0; m_jerr = 0; m_ut = 0; m_dt = 0;
            return;
        end
        stable = (hist.size() == S);
        if (stable) begin
            for (int i = 1; i < S; i++) if (hist[i] != hist[0]) stable = 0;
        end
        jset = 0;
        if (stable) begin
            cand = int'(hist[S-1]);
            if (!m_valid || cand != m_count_q) begin
                if (m_valid) begin
                    d = (cand - m_count_q + 16) % 16;
                    if (d == 1) begin
                        m_up = 1; m_wrap = (m_count_q == 15); m_derr = !dir_up;
                        if (m_ut < (1 << TW) - 1) m_ut++;
                    end else if (d == 15) begin
                        m_dn = 1; m_wrap = (m_count_q == 0); m_derr = dir_up;
                        if (m_dt < (1 << TW) - 1) m_dt++;
                    end else begin
                        jset = 1;
                    end
                end
                m_valid   = 1;
                m_count_q = cand;
                m_match   = (cand == int'(cmp_val));
            end
        end
        if (jset) m_jerr = 1;
        else if (clr_err) m_jerr = 0;
        hist.push_back(count_in);
        if (hist.size() > S) void'(hist.pop_front());
    endtask

    task automatic compare();
        chk("count_q",    int'(count_q),    m_count_q);
        chk("valid",      int'(valid),      int'(m_valid));
        chk("step_up",    int'(step_up),    int'(m_up));
        chk("step_down",  int'(step_down),  int'(m_dn));
        chk("wrap",       int'(wrap),       int'(m_wrap));
        chk("match",      int'(match),      int'(m_match));
        chk("dir_err",    int'(dir_err),    int'(m_derr));
        chk("jump_err",   int'(jump_err),   int'(m_jerr));
        chk("up_tally",   int'(up_tally),   m_ut);
        chk("down_tally", int'(down_tally), m_dt);
        n_up    += int'(step_up);
        n_dn    += int'(step_down);
        n_wrap  += int'(wrap);
        n_match += int'(match);
        n_derr  += int'(dir_err);
    endtask

    // One clock: model and check just after the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        count_in = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int b_up, b_dn, b_wrap, b_match, b_derr;

    task automatic snap();
        b_up = n_up; b_dn = n_dn; b_wrap = n_wrap; b_match = n_match; b_derr = n_derr;
    endtask

    initial begin
        reset    = 1'b1;
        count_in = 4'd0;
        dir_up   = 1'b1;
        cmp_val  = 4'hA;
        clr_err  = 1'b0;
        @(negedge clk);
        tick();
        chk("rst_count_q", int'(count_q), 0);
        chk("rst_valid",   int'(valid),   0);
        chk("rst_tally",   int'(up_tally) + int'(down_tally), 0);

        // 1: first accept lands two edges after the first sample
        reset = 1'b0;
        snap();
        count_in = 4'd5;
        tick();
        chk("s1_e0_count_q", int'(count_q), 0);
        tick();
        chk("s1_e1_valid", int'(valid), 0);
        tick();
        chk("s1_e2_count_q", int'(count_q), 5);
        chk("s1_e2_valid",   int'(valid),   1);
        chk("s1_no_step",    n_up - b_up + n_dn - b_dn, 0);

        // 2: up sequence with a 15->0 wrap
        do_reset();
        snap();
        dir_up = 1'b1;
        hold(4'd13, 4); hold(4'd14, 4); hold(4'd15, 4); hold(4'd0, 4); hold(4'd1, 4);
        chk("s2_step_up", n_up - b_up, 4);
        chk("s2_wrap",    n_wrap - b_wrap, 1);
        chk("s2_tally",   int'(up_tally), 4);
        chk("s2_dir_err", n_derr - b_derr, 0);

        // 3: down sequence with 0->15 wrap, then direction disagreement
        do_reset();
        snap();
        dir_up = 1'b0;
        hold(4'd1, 4); hold(4'd0, 4); hold(4'd15, 4);
        chk("s3_step_down", n_dn - b_dn, 2);
        chk("s3_wrap",      n_wrap - b_wrap, 1);
        chk("s3_dir_err0",  n_derr - b_derr, 0);
        dir_up = 1'b1;
        hold(4'd14, 4); hold(4'd13, 4);
        chk("s3_dir_err1",  n_derr - b_derr, 2);
        chk("s3_tally",     int'(down_tally), 4);

        // 4: short glitch rejected, jump error sticky, clear and set-wins
        do_reset();
        hold(4'd7, 4);
        snap();
        count_in = 4'd4;
        tick();
        hold(4'd7, 4);
        chk("s4_glitch_q",   int'(count_q), 7);
        chk("s4_glitch_evt", (n_up - b_up) + (n_dn - b_dn) + (n_match - b_match), 0);
        hold(4'd10, 4);
        chk("s4_jump_q",   int'(count_q), 10);
        chk("s4_jump_err", int'(jump_err), 1);
        chk("s4_jump_nostep", (n_up - b_up) + (n_dn - b_dn) + (n_wrap - b_wrap), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("s4_cleared", int'(jump_err), 0);
        count_in = 4'd3;
        tick();
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("s4_set_wins", int'(jump_err), 1);
        chk("s4_set_q",    int'(count_q), 3);
        tick();
        chk("s4_sticky", int'(jump_err), 1);

        // 5: single match, then tally saturation
        do_reset();
        cmp_val = 4'd9;
        dir_up  = 1'b1;
        snap();
        for (int v = 5; v <= 12; v++) hold(4'(v), 3);
        chk("s5_match", n_match - b_match, 1);
        for (int i = 0; i < 300; i++) hold(4'((13 + i) % 16), 2);
        tick();
        chk("s5_up_sat",   int'(up_tally), 255);
        chk("s5_down_zero", int'(down_tally), 0);

        // 6: reset in the middle of a window forgets all history
        do_reset();
        cmp_val = 4'hA;
        hold(4'd3, 4);
        hold(4'd4, 4);
        count_in = 4'd5;
        tick();
        reset = 1'b1;
        #1;
        chk("s6_rst_q",     int'(count_q), 0);
        chk("s6_rst_valid", int'(valid), 0);
        chk("s6_rst_tally", int'(up_tally), 0);
        @(negedge clk);
        tick();
        reset = 1'b0;
        snap();
        tick();
        tick();
        chk("s6_pre_valid", int'(valid), 0);
        tick();
        chk("s6_q",       int'(count_q), 5);
        chk("s6_valid",   int'(valid), 1);
        chk("s6_no_step", (n_up - b_up) + (n_dn - b_dn), 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
